// File: rtl/apb_timer_multi_if.sv
// rtl/apb_timer_multi_if.sv - APB slave bus bundle for the multi-channel timer
interface apb_timer_multi_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int TIMER_BITS = 16
);
   logic                  sel;
   logic                  enable;
   logic                  write;
   logic [ADDR_WIDTH-1:0] addr;
   logic [TIMER_BITS-1:0] wdata;
   logic [TIMER_BITS-1:0] rdata;
   logic                  ready;
   logic                  slverr;

   modport master (
      output sel, enable, write, addr, wdata,
      input  rdata, ready, slverr
   );

   modport slave (
      input  sel, enable, write, addr, wdata,
      output rdata, ready, slverr
   );
endinterface

// File: rtl/apb_timer_multi.sv
// rtl/apb_timer_multi.sv - NUM_CH goal-compare up-counters behind a one-wait-state APB slave
module apb_timer_multi #(
   parameter int NUM_CH     = 4,
   parameter int TIMER_BITS = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              reset,
   apb_timer_multi_if.slave  bus,
   output logic [NUM_CH-1:0] irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   localparam logic [ADDR_WIDTH:0] LO_ADDR = (ADDR_WIDTH+1)'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] HI_ADDR = (ADDR_WIDTH+1)'(BASE_ADDR + 4*NUM_CH);

   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] off_q, off_d;
   logic [TIMER_BITS-1:0] wdata_q, wdata_d;

   logic [NUM_CH-1:0]     en_q, en_d;
   logic [NUM_CH-1:0]     per_q, per_d;
   logic [NUM_CH-1:0]     ie_q, ie_d;
   logic [NUM_CH-1:0]     done_q, done_d;
   logic [TIMER_BITS-1:0] goal_q [NUM_CH];
   logic [TIMER_BITS-1:0] goal_d [NUM_CH];
   logic [TIMER_BITS-1:0] count_q [NUM_CH];
   logic [TIMER_BITS-1:0] count_d [NUM_CH];

   logic                  in_range;
   logic [ADDR_WIDTH-1:0] off_now;
   logic                  err_now;
   logic                  commit;
   logic [NUM_CH-1:0]     ch_hit;
   logic [TIMER_BITS-1:0] rd_val;

   // Decode of the live bus address, captured at the SETUP->ACCESS edge.
   always_comb begin
      in_range = ({1'b0, bus.addr} >= LO_ADDR) && ({1'b0, bus.addr} < HI_ADDR);
      off_now  = bus.addr - LO_ADDR[ADDR_WIDTH-1:0];
      err_now  = !in_range || (bus.write && (off_now[1:0] == 2'd2));
   end

   always_comb begin
      ch_hit = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_hit[c] = (32'(off_q >> 2) == 32'(c));
      end
   end

   assign commit = (state_q == S_ACCESS) && write_q && !err_q;

   always_comb begin
      state_d = state_q;
      ready_d = 1'b0;
      err_d   = err_q;
      write_d = write_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.sel && !bus.enable) begin
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (!bus.sel) begin
               state_d = S_IDLE;
            end else if (bus.enable) begin
               state_d = S_ACCESS;
               ready_d = 1'b1;
               err_d   = err_now;
               write_d = bus.write;
               off_d   = off_now;
               wdata_d = bus.wdata;
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.sel && !bus.enable) begin
               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Per-channel counters. A CTRL write on the terminal-count edge takes
   // precedence over that edge's counter update; a hardware DONE set beats W1C.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         en_d[c]    = en_q[c];
         per_d[c]   = per_q[c];
         ie_d[c]    = ie_q[c];
         done_d[c]  = done_q[c];
         goal_d[c]  = goal_q[c];
         count_d[c] = count_q[c];

         if (commit && ch_hit[c] && (off_q[1:0] == 2'd3) && wdata_q[0]) begin
            done_d[c] = 1'b0;
         end
         if (commit && ch_hit[c] && (off_q[1:0] == 2'd1)) begin
            goal_d[c] = wdata_q;
         end

         if (commit && ch_hit[c] && (off_q[1:0] == 2'd0)) begin
            en_d[c]  = wdata_q[0];
            per_d[c] = wdata_q[1];
            ie_d[c]  = wdata_q[2];
            if (wdata_q[3]) begin
               count_d[c] = '0;
            end
         end else if (en_q[c]) begin
            if (count_q[c] == goal_q[c]) begin
               done_d[c] = 1'b1;
               if (per_q[c]) begin
                  count_d[c] = '0;
               end else begin
                  en_d[c] = 1'b0;
               end
            end else begin
               count_d[c] = count_q[c] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_val = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_hit[c]) begin
            case (off_q[1:0])
               2'd0:    rd_val = TIMER_BITS'({ie_q[c], per_q[c], en_q[c]});
               2'd1:    rd_val = goal_q[c];
               2'd2:    rd_val = count_q[c];
               default: rd_val = TIMER_BITS'({en_q[c], done_q[c]});
            endcase
         end
      end
   end

   assign bus.rdata  = (ready_q && !err_q && !write_q) ? rd_val : '0;
   assign bus.ready  = ready_q;
   assign bus.slverr = ready_q & err_q;
   assign irq        = done_q & ie_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         write_q <= 1'b0;
         off_q   <= '0;
         wdata_q <= '0;
         en_q    <= '0;
         per_q   <= '0;
         ie_q    <= '0;
         done_q  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            goal_q[c]  <= '0;
            count_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         write_q <= write_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         en_q    <= en_d;
         per_q   <= per_d;
         ie_q    <= ie_d;
         done_q  <= done_d;
         for (int c = 0; c < NUM_CH; c++) begin
            goal_q[c]  <= goal_d[c];
            count_q[c] <= count_d[c];
         end
      end
   end

endmodule

// File: tb/tb_apb_timer_multi.sv
// tb/tb_apb_timer_multi.sv - directed scoreboard bench for apb_timer_multi
module tb_apb_timer_multi;

   localparam int NCH  = 4;
   localparam int TB   = 16;
   localparam int AW   = 6;
   localparam int BASE = 8;

   typedef struct {
      logic          chk_data;
      logic          err;
      logic [TB-1:0] data;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [NCH-1:0] irq;
   int             cyc = 0;
   int             vectors = 0;
   int             miscompares = 0;
   int             last_commit = 0;
   int             c0, c1, c2, s;
   exp_t           sb_q[$];

   apb_timer_multi_if #(.ADDR_WIDTH(AW), .TIMER_BITS(TB)) bus ();

   apb_timer_multi #(
      .NUM_CH(NCH), .TIMER_BITS(TB), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [AW-1:0] ra(input int ch, input int r);
      return AW'(BASE + 4*ch + r);
   endfunction

   function automatic logic [TB-1:0] cnt_os(input int k, input int g);
      return TB'((k > g) ? g : k);
   endfunction

   function automatic logic [TB-1:0] cnt_per(input int k, input int g);
      return TB'(k % (g + 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full APB transfer; the access edge is three edges after the call.
   task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [TB-1:0] wd,
                       input logic [TB-1:0] exp_data, input logic exp_err, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      bus.sel    = 1'b1;
      bus.enable = 1'b0;
      bus.write  = wr;
      bus.addr   = a;
      bus.wdata  = wd;
      sb_q.push_back('{chk_data: !wr, err: exp_err, data: exp_data});
      @(posedge clk);
      #1;
      bus.enable = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "/ready"}, 32'(bus.ready), 32'd1);
      e = sb_q.pop_front();
      chk({tag, "/slverr"}, 32'(bus.slverr), 32'(e.err));
      if (e.chk_data) chk({tag, "/rdata"}, 32'(bus.rdata), 32'(e.data));
      @(posedge clk);
      #1;
      last_commit = cyc;
      chk({tag, "/ready_low"}, 32'(bus.ready), 32'd0);
      bus.sel    = 1'b0;
      bus.enable = 1'b0;
   endtask

   initial begin
      bus.sel    = 1'b0;
      bus.enable = 1'b0;
      bus.write  = 1'b0;
      bus.addr   = '0;
      bus.wdata  = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst/ready", 32'(bus.ready), 32'd0);
      chk("rst/rdata", 32'(bus.rdata), 32'd0);
      chk("rst/slverr", 32'(bus.slverr), 32'd0);
      chk("rst/irq", 32'(irq), 32'd0);
      reset = 1'b0;

      for (int c = 0; c < NCH; c++) begin
         for (int r = 0; r < 4; r++) begin
            xfer(1'b0, ra(c, r), '0, '0, 1'b0, "rst_read");
         end
      end
      chk("rst/irq_after_reads", 32'(irq), 32'd0);

      // ch0 one-shot, GOAL=5, IRQ enabled
      xfer(1'b1, ra(0, 1), 16'd5, '0, 1'b0, "ch0_goal");
      xfer(1'b1, ra(0, 0), 16'h5, '0, 1'b0, "ch0_ctrl");
      c0 = last_commit;
      s = cyc;
      xfer(1'b0, ra(0, 2), '0, cnt_os(s + 3 - c0, 5), 1'b0, "ch0_count_run");
      while (cyc - c0 < 8) begin
         @(posedge clk);
         #1;
         chk("ch0_irq_edge", 32'(irq), (cyc - c0 >= 6) ? 32'h1 : 32'h0);
      end
      xfer(1'b0, ra(0, 2), '0, 16'd5, 1'b0, "ch0_count_hold");
      xfer(1'b0, ra(0, 0), '0, 16'h4, 1'b0, "ch0_ctrl_en_clr");
      xfer(1'b0, ra(0, 3), '0, 16'h1, 1'b0, "ch0_status_done");
      xfer(1'b1, ra(0, 3), 16'h1, '0, 1'b0, "ch0_w1c");
      chk("ch0_irq_cleared", 32'(irq), 32'd0);
      xfer(1'b0, ra(0, 3), '0, 16'h0, 1'b0, "ch0_status_clr");

      // ch2 periodic, GOAL=3; varying gaps sample every phase of the period
      xfer(1'b1, ra(2, 1), 16'd3, '0, 1'b0, "ch2_goal");
      xfer(1'b1, ra(2, 0), 16'h3, '0, 1'b0, "ch2_ctrl");
      c2 = last_commit;
      for (int g = 0; g < 5; g++) begin
         idle(g);
         s = cyc;
         xfer(1'b0, ra(2, 2), '0, cnt_per(s + 3 - c2, 3), 1'b0, "ch2_count");
      end
      xfer(1'b0, ra(2, 3), '0, 16'h3, 1'b0, "ch2_status");
      chk("ch2_irq_masked", 32'(irq), 32'd0);
      xfer(1'b0, ra(1, 2), '0, 16'd0, 1'b0, "ch1_count_idle");
      xfer(1'b0, ra(3, 2), '0, 16'd0, 1'b0, "ch3_count_idle");
      xfer(1'b0, ra(0, 2), '0, 16'd5, 1'b0, "ch0_count_untouched");

      // error responses
      xfer(1'b1, ra(1, 2), 16'h55, '0, 1'b1, "wr_count_err");
      xfer(1'b0, ra(1, 2), '0, 16'd0, 1'b0, "ch1_count_after_err");
      xfer(1'b0, AW'(BASE + 4*NCH), '0, 16'd0, 1'b1, "oor_read");
      xfer(1'b1, AW'(BASE + 4*NCH), 16'hFFFF, '0, 1'b1, "oor_write");
      xfer(1'b0, AW'(BASE - 4), '0, 16'd0, 1'b1, "below_base_read");
      xfer(1'b0, AW'(63), '0, 16'd0, 1'b1, "top_addr_read");
      xfer(1'b0, ra(0, 1), '0, 16'd5, 1'b0, "ch0_goal_kept");
      xfer(1'b0, ra(3, 0), '0, 16'd0, 1'b0, "ch3_ctrl_kept");

      // reset while a read sits in ACCESS and ch0 is counting
      xfer(1'b1, ra(0, 0), 16'h9, '0, 1'b0, "ch0_restart");
      @(posedge clk);
      #1;
      bus.sel   = 1'b1;
      bus.write = 1'b0;
      bus.addr  = ra(0, 2);
      @(posedge clk);
      #1;
      bus.enable = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst/ready_before", 32'(bus.ready), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst/ready", 32'(bus.ready), 32'd0);
      chk("midrst/rdata", 32'(bus.rdata), 32'd0);
      chk("midrst/irq", 32'(irq), 32'd0);
      reset      = 1'b0;
      bus.sel    = 1'b0;
      bus.enable = 1'b0;
      xfer(1'b0, ra(0, 0), '0, 16'd0, 1'b0, "midrst_ch0_ctrl");
      xfer(1'b0, ra(0, 2), '0, 16'd0, 1'b0, "midrst_ch0_count");
      xfer(1'b0, ra(2, 0), '0, 16'd0, 1'b0, "midrst_ch2_ctrl");
      xfer(1'b0, ra(2, 3), '0, 16'd0, 1'b0, "midrst_ch2_status");

      // CTRL write landing on ch0's terminal-count edge
      xfer(1'b1, ra(0, 1), 16'd10, '0, 1'b0, "tc_goal");
      xfer(1'b1, ra(0, 0), 16'h1, '0, 1'b0, "tc_ctrl");
      c0 = last_commit;
      idle(7);
      xfer(1'b1, ra(0, 0), 16'h9, '0, 1'b0, "tc_ctrl_clear");
      c1 = last_commit;
      chk("tc_commit_edge", 32'(c1 - c0), 32'd11);
      xfer(1'b0, ra(0, 3), '0, 16'h2, 1'b0, "tc_status_no_done");
      s = cyc;
      xfer(1'b0, ra(0, 2), '0, cnt_os(s + 3 - c1, 10), 1'b0, "tc_count_restart");

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/apb_timer_multi.md
Name: apb_timer_multi

Overview:
- Parameterised multi-channel successor to the single-channel APB timer.
- NUM_CH independent up-counters, each with its own goal register, one-shot or periodic mode, sticky done flag and maskable interrupt.
- Sits as an APB slave on the peripheral bus; irq lines go to the interrupt controller.
- Fixed one-wait-state APB handshake with error response for illegal accesses.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
TIMER_BITS, 16, counter/goal/data width (>=4)
ADDR_WIDTH, 6, APB address width; must satisfy 2^ADDR_WIDTH >= BASE_ADDR + 4*NUM_CH
BASE_ADDR, 0, first register address; multiple of 4

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
sel  input  1  APB select
enable  input  1  APB enable (access phase)
write  input  1  1 = write, 0 = read
addr  input  ADDR_WIDTH  register address
wdata  input  TIMER_BITS  write data
rdata  output  TIMER_BITS  read data; valid only while ready=1
ready  output  1  transfer completion
slverr  output  1  error response; valid only while ready=1
irq  output  NUM_CH  per-channel interrupt, irq[c] = DONE[c] & IRQ_EN[c]

Behaviour:
- One clock; reset is synchronous and active-high. Reset clears all channel registers, counters and flags. Outputs go to rdata=0, ready=0, slverr=0, irq=0. A transfer in flight is aborted with no register change.
- Address decode: off = addr - BASE_ADDR; ch = off[..:2]; reg = off[1:0]. addr < BASE_ADDR or off >= 4*NUM_CH is out of range.
- Registers per channel:
  - reg0 CTRL, RW. Bit0 EN, bit1 PERIODIC, bit2 IRQ_EN. Bit3 CLEAR is write-only and self-clearing: writing 1 zeroes COUNT. CTRL reads bit3 as 0, upper bits 0.
  - reg1 GOAL, RW.
  - reg2 COUNT, RO.
  - reg3 STATUS. Bit0 DONE: sticky, write-1-to-clear. Bit1 RUNNING: read-only, equals EN.
- APB handshake FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE -> SETUP on sel & !enable.
  - SETUP -> ACCESS on sel & enable. Address, write and wdata are captured on this edge.
  - ACCESS: ready=1 for exactly one cycle (one wait state). Write commits on the edge leaving ACCESS. rdata and slverr are driven during ACCESS.
  - ACCESS -> RESP. RESP -> IDLE, or -> SETUP if sel & !enable.
  - sel dropping in SETUP returns the FSM to IDLE.
  - rdata=0 whenever ready=0.
- slverr=1 (with ready) for: an out-of-range address, or a write to COUNT. An erroring write changes no state. An out-of-range read returns 0.
- Counting, per channel, each edge with EN=1:
  - If COUNT == GOAL: DONE<=1. If PERIODIC, COUNT<=0. Otherwise COUNT holds and EN<=0.
  - Else COUNT<=COUNT+1.
  - Period is GOAL+1 cycles. COUNT never exceeds GOAL during normal counting.
- EN=0: COUNT holds.
- GOAL written below the current COUNT while running: on the next edge COUNT wraps modulo 2^TIMER_BITS and continues until it equals GOAL. No saturation.
- GOAL=0: periodic sets DONE every cycle with COUNT=0; one-shot sets DONE on the first enabled cycle and clears EN.
- Simultaneous events:
  - Hardware DONE set and W1C in the same edge: set wins.
  - A CTRL write to a channel on the same edge as its terminal count: the written CTRL and CLEAR take effect, the counter update for that edge is suppressed, and DONE is not set.
  - Other channels are unaffected.
- irq is combinational from the registered DONE and IRQ_EN bits, with no extra latency.

Test Plan:
- Reset, then read all 4*NUM_CH registers -> every read returns 0, slverr=0, ready high exactly one cycle per transfer, irq=0.
- ch0: GOAL=5, CTRL=0x5 (EN, IRQ_EN, one-shot) -> COUNT reads 0..5 over 6 cycles. DONE and irq[0] rise on the 6th enabled edge. EN clears, COUNT holds 5. W1C STATUS=1 -> irq[0]=0.
- ch2: GOAL=3, CTRL=0x3 (periodic) -> DONE set every 4 cycles, COUNT sequence 0,1,2,3,0. ch1 and ch3 COUNT stay 0.
- Write COUNT of ch1, and access addr = BASE_ADDR+4*NUM_CH -> slverr=1 with ready. No register changes. The read returns 0.
- Assert reset mid-transfer (ACCESS state) while ch0 is running -> next cycle ready=0, COUNT=0, CTRL=0, FSM in IDLE.
- ch0 at COUNT==GOAL receives a CTRL write 0x9 (EN, CLEAR) on the same edge -> COUNT=0, DONE stays 0, counting restarts.
